// File: rtl/uart_report_sched.sv
// Periodic / on-demand temperature report scheduler feeding a byte-wide UART.
// A tick counter or a host request queues a report (or alarm) message; the
// FSM snapshots the BCD inputs and streams 12 ASCII bytes with valid/ready.
`timescale 1ns/1ps

module uart_report_sched #(
    parameter int unsigned REPORT_DIV   = 12_000_000,
    parameter int unsigned ALARM_THRESH = 35
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] temp_hun,
    input  logic [3:0] temp_ten,
    input  logic [3:0] temp_unit,
    input  logic [3:0] time_hour_high,
    input  logic [3:0] time_hour_low,
    input  logic [3:0] time_min_high,
    input  logic [3:0] time_min_low,
    input  logic       cmd_req,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       alarm_active
);

    localparam int unsigned CNT_W   = (REPORT_DIV > 1) ? $clog2(REPORT_DIV) : 1;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned MSG_LEN = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [6:0][3:0]  snap, snap_next;
    logic             msg_alarm, msg_alarm_next;
    logic             alarm_pend, alarm_pend_next;
    logic             rep_pend, rep_pend_next;
    logic             cmd_d;
    logic             tx_valid_next;
    logic [7:0]       tx_data_next;
    logic             busy_next;
    logic             alarm_active_next;

    logic             tick;
    logic             cmd_rise;
    logic [7:0]       temp_val;
    logic             over_thresh;
    logic             clr_alarm, clr_rep;

    // ASCII for one BCD digit; non-decimal codes become '?'
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + 8'(d));
    endfunction

    // Byte idx of the selected message; snapshot order is hun,ten,unit,hh,hl,mh,ml
    function automatic logic [7:0] msg_byte(input logic is_alarm,
                                            input logic [6:0][3:0] s,
                                            input logic [IDX_W-1:0] i);
        logic [7:0] b;
        b = 8'h0A;
        if (is_alarm) begin
            case (i)
                4'd0:    b = "T";
                4'd1:    b = "e";
                4'd2:    b = "m";
                4'd3:    b = "p";
                4'd4:    b = "A";
                4'd5:    b = "l";
                4'd6:    b = "a";
                4'd7:    b = "r";
                4'd8:    b = "m";
                4'd9:    b = "!";
                4'd10:   b = "!";
                default: b = 8'h0A;
            endcase
        end else begin
            case (i)
                4'd0:    b = digit_ascii(s[6]);
                4'd1:    b = digit_ascii(s[5]);
                4'd2:    b = ".";
                4'd3:    b = digit_ascii(s[4]);
                4'd4:    b = "C";
                4'd5:    b = " ";
                4'd6:    b = digit_ascii(s[3]);
                4'd7:    b = digit_ascii(s[2]);
                4'd8:    b = ":";
                4'd9:    b = digit_ascii(s[1]);
                4'd10:   b = digit_ascii(s[0]);
                default: b = 8'h0A;
            endcase
        end
        return b;
    endfunction

    // Report period strobe, request edge detect and alarm comparison
    assign tick        = (tick_cnt == CNT_W'(REPORT_DIV - 1));
    assign cmd_rise    = cmd_req & ~cmd_d;
    assign temp_val    = 8'(temp_hun) * 8'd10 + 8'(temp_ten);
    assign over_thresh = (temp_val >= 8'(ALARM_THRESH));

    // State and datapath registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            idx          <= '0;
            snap         <= '0;
            msg_alarm    <= 1'b0;
            alarm_pend   <= 1'b0;
            rep_pend     <= 1'b0;
            cmd_d        <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            busy         <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_cnt_next;
            idx          <= idx_next;
            snap         <= snap_next;
            msg_alarm    <= msg_alarm_next;
            alarm_pend   <= alarm_pend_next;
            rep_pend     <= rep_pend_next;
            cmd_d        <= cmd_req;
            tx_valid     <= tx_valid_next;
            tx_data      <= tx_data_next;
            busy         <= busy_next;
            alarm_active <= alarm_active_next;
        end
    end

    // Next-state, pend-flag bookkeeping and next output byte
    always_comb begin
        state_next        = state;
        tick_cnt_next     = tick ? '0 : tick_cnt + CNT_W'(1);
        idx_next          = idx;
        snap_next         = snap;
        msg_alarm_next    = msg_alarm;
        tx_valid_next     = tx_valid;
        alarm_active_next = tick ? over_thresh : alarm_active;
        clr_alarm         = 1'b0;
        clr_rep           = 1'b0;

        unique case (state)
            IDLE: begin
                tx_valid_next = 1'b0;
                if (alarm_pend || rep_pend) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                snap_next      = {temp_hun, temp_ten, temp_unit,
                                  time_hour_high, time_hour_low,
                                  time_min_high, time_min_low};
                msg_alarm_next = alarm_pend;
                clr_alarm      = alarm_pend;
                clr_rep        = ~alarm_pend;
                idx_next       = '0;
                tx_valid_next  = 1'b1;
                state_next     = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx == IDX_W'(MSG_LEN - 1)) begin
                        idx_next      = '0;
                        tx_valid_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                tx_valid_next = 1'b0;
                state_next    = IDLE;
            end
        endcase

        // A set arriving in the same cycle as the LOAD clear survives
        alarm_pend_next = (alarm_pend & ~clr_alarm) | (tick & over_thresh);
        rep_pend_next   = (rep_pend & ~clr_rep) | (tick & ~over_thresh) | cmd_rise;

        tx_data_next = tx_valid_next ? msg_byte(msg_alarm_next, snap_next, idx_next) : tx_data;
        busy_next    = (state_next != IDLE);
    end

endmodule
